async_rr_arbiter: RTL and testbench

ASYNC_RR_ARBITER -- requirements
Module: async_rr_arbiter

---
 rtl/async_rr_arbiter.sv | 82 ++++++++
 tb/tb_async_rr_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/async_rr_arbiter.sv
// async_rr_arbiter: per-input slot registers drained round-robin to one consumer over req/ack handshakes.
// Optional ASYNC_RR_ARBITER_COUNT_EN adds grant_count, a 32-bit delivered-word counter per input.
module async_rr_arbiter #(
  parameter int data_width = 32,
  parameter int num_inputs = 4,
  parameter int id_width   = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic [num_inputs-1:0]            req_l,
  input  logic [num_inputs-1:0]            ack_l,
  input  logic [data_width*num_inputs-1:0] din,
  input  logic                             req_r,
  output logic                             ack_r,
  output logic [data_width-1:0]            dout,
  output logic [id_width-1:0]              dout_id
`ifdef ASYNC_RR_ARBITER_COUNT_EN
  ,
  output logic [32*num_inputs-1:0]         grant_count
`endif
);
  logic [num_inputs-1:0] r_full;
  logic [data_width-1:0] r_data [num_inputs];
  logic [id_width-1:0]   r_p;
  logic [id_width-1:0]   w_sel;
  logic [data_width-1:0] w_data;
  logic                  w_deliver;
  int                    w_dist;
  int                    w_best;
  assign w_deliver = req_r & ~ack_r & (|r_full);
  // winner is the full slot with the smallest rotational distance from the pointer
  always_comb begin
    w_sel  = '0;
    w_data = '0;
    w_dist = 0;
    w_best = num_inputs;
    for (int i = 0; i < num_inputs; i++) begin
      w_dist = (i >= int'(r_p)) ? i - int'(r_p) : i + num_inputs - int'(r_p);
      if (r_full[i] && w_dist < w_best) begin
        w_best = w_dist;
        w_sel  = id_width'(i);
        w_data = r_data[i];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      req_l   <= '0;
      r_full  <= '0;
      ack_r   <= 1'b0;
      dout    <= '0;
      dout_id <= '0;
      r_p     <= '0;
    end else begin
      for (int i = 0; i < num_inputs; i++) begin
        if (ack_l[i] && !r_full[i]) begin
          r_full[i] <= 1'b1;
          r_data[i] <= din[data_width*i +: data_width];
          req_l[i]  <= 1'b0;
        end else if (!r_full[i] && !req_l[i]) begin
          req_l[i] <= 1'b1;
        end
        if (w_deliver && w_sel == id_width'(i)) r_full[i] <= 1'b0;
      end
      ack_r <= w_deliver;
      if (w_deliver) begin
        dout    <= w_data;
        dout_id <= w_sel;
        r_p     <= (w_sel == id_width'(num_inputs - 1)) ? '0 : w_sel + 1'b1;
      end
    end
  end
`ifdef ASYNC_RR_ARBITER_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) grant_count <= '0;
    else
      for (int i = 0; i < num_inputs; i++)
        if (w_deliver && w_sel == id_width'(i))
          grant_count[32*i +: 32] <= grant_count[32*i +: 32] + 32'd1;
  end
`endif
endmodule

// File: tb/tb_async_rr_arbiter.sv
// tb_async_rr_arbiter: directed and random stimulus against a cycle model; deliveries checked via a scoreboard queue.
module tb_async_rr_arbiter;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   req_l;
  logic [3:0]   ack_l = '0;
  logic [127:0] din = '0;
  logic         req_r = 1'b0;
  logic         ack_r;
  logic [31:0]  dout;
  logic [1:0]   dout_id;
`ifdef ASYNC_RR_ARBITER_COUNT_EN
  logic [127:0] grant_count;
`endif

  async_rr_arbiter dut (
    .clk(clk), .rst(rst), .req_l(req_l), .ack_l(ack_l), .din(din),
    .req_r(req_r), .ack_r(ack_r), .dout(dout), .dout_id(dout_id)
`ifdef ASYNC_RR_ARBITER_COUNT_EN
    , .grant_count(grant_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int id; logic [31:0] d; } exp_t;
  exp_t        sbq[$];
  exp_t        e;
  bit          m_full[4];
  logic [31:0] m_data[4];
  bit          m_req[4];
  bit          m_ackr;
  int          m_p;
  logic [31:0] m_dout;
  int          m_id;
  int          m_cnt[4];
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (ack_r === 1'b1) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL mon_unexpected: ack_r with dout=%0h id=%0d, expected none", dout, dout_id);
      end else begin
        e = sbq.pop_front();
        chk("mon_id", 128'(dout_id), 128'(e.id));
        chk("mon_dout", 128'(dout), 128'(e.d));
      end
    end
  end

  task automatic step(input logic r, input logic [3:0] a, input logic rq, input logic [127:0] d);
    int sel;
    logic [3:0] mr;
    rst = r; ack_l = a; req_r = rq; din = d;
    if (r) begin
      for (int i = 0; i < 4; i++) begin m_full[i] = 0; m_req[i] = 0; m_cnt[i] = 0; end
      m_ackr = 0; m_p = 0; m_dout = '0; m_id = 0;
    end else begin
      sel = -1;
      if (rq && !m_ackr)
        for (int k = 0; k < 4; k++)
          if (sel < 0 && m_full[(m_p + k) % 4]) sel = (m_p + k) % 4;
      for (int i = 0; i < 4; i++) begin
        if (a[i] && !m_full[i]) begin
          m_full[i] = 1; m_data[i] = d[32*i +: 32]; m_req[i] = 0;
        end else if (!m_full[i] && !m_req[i] && !a[i]) begin
          m_req[i] = 1;
        end
      end
      m_ackr = (sel >= 0);
      if (sel >= 0) begin
        m_full[sel] = 0;
        e.id = sel; e.d = m_data[sel];
        sbq.push_back(e);
        m_dout = m_data[sel]; m_id = sel; m_p = (sel + 1) % 4;
        m_cnt[sel]++;
      end
    end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) mr[i] = m_req[i];
    chk("req_l", 128'(req_l), 128'(mr));
    chk("ack_r", 128'(ack_r), 128'(m_ackr));
    chk("dout_hold", 128'(dout), 128'(m_dout));
    chk("dout_id_hold", 128'(dout_id), 128'(m_id));
  endtask

  task automatic idle(input int n, input logic rq);
    for (int i = 0; i < n; i++) step(1'b0, 4'b0, rq, '0);
  endtask

  initial begin
    logic [3:0] a;
    step(1'b1, 4'b0, 1'b1, '0);
    chk("rst_req_l", 128'(req_l), 128'(0));
    chk("rst_ack_r", 128'(ack_r), 128'(0));
    chk("rst_dout", 128'(dout), 128'(0));
    chk("rst_dout_id", 128'(dout_id), 128'(0));
    step(1'b1, 4'b0, 1'b1, '0);
    step(1'b0, 4'b0, 1'b1, '0);
    chk("req_after_rst", 128'(req_l), 128'(4'hF));
    idle(3, 1'b1);
    chk("no_ack_idle", 128'(ack_r), 128'(0));
    // single input 2, latency and req_l re-assertion
    step(1'b0, 4'b0100, 1'b1, {32'h0, 32'h55, 32'h0, 32'h0});
    chk("req2_low_t1", 128'(req_l[2]), 128'(0));
    idle(1, 1'b1);
    chk("lat_ack", 128'(ack_r), 128'(1));
    chk("lat_dout", 128'(dout), 128'(32'h55));
    chk("lat_id", 128'(dout_id), 128'(2));
    chk("req2_low_t2", 128'(req_l[2]), 128'(0));
    idle(1, 1'b1);
    chk("req2_high_t3", 128'(req_l[2]), 128'(1));
    // all four at once from reset
    step(1'b1, 4'b0, 1'b0, '0);
    step(1'b0, 4'b0, 1'b1, '0);
    step(1'b0, 4'hF, 1'b1, {32'd40, 32'd30, 32'd20, 32'd10});
    idle(10, 1'b1);
    // slots 1 and 3 full with pointer at 2
    step(1'b1, 4'b0, 1'b0, '0);
    step(1'b0, 4'b0, 1'b0, '0);
    step(1'b0, 4'b0010, 1'b1, {32'h0, 32'h0, 32'hA1, 32'h0});
    idle(4, 1'b1);
    step(1'b0, 4'b1010, 1'b0, {32'hB3, 32'h0, 32'hB1, 32'h0});
    idle(2, 1'b0);
    idle(6, 1'b1);
    // consumer stalled for ten cycles
    step(1'b0, 4'hF, 1'b0, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
    idle(10, 1'b0);
    chk("stall_req_low", 128'(req_l), 128'(0));
    idle(10, 1'b1);
    // reset with two full slots
    step(1'b0, 4'b0101, 1'b0, {32'h0, 32'hD2, 32'h0, 32'hD0});
    step(1'b1, 4'b0, 1'b0, '0);
    idle(5, 1'b1);
`ifdef ASYNC_RR_ARBITER_COUNT_EN
    chk("cnt_after_rst", grant_count, 128'(0));
`endif
    // random traffic, including acks into full slots and occasional reset
    for (int n = 0; n < 2000; n++) begin
      for (int i = 0; i < 4; i++)
        a[i] = (m_req[i] && $urandom_range(0, 2) == 0) || (m_full[i] && $urandom_range(0, 19) == 0);
      step($urandom_range(0, 199) == 0, a, $urandom_range(0, 9) < 7,
           {$urandom, $urandom, $urandom, $urandom});
    end
    idle(20, 1'b1);
    chk("sb_empty", 128'(sbq.size()), 128'(0));
`ifdef ASYNC_RR_ARBITER_COUNT_EN
    for (int i = 0; i < 4; i++) chk("grant_count", 128'(grant_count[32*i +: 32]), 128'(m_cnt[i]));
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
